// File: rtl/string_char_streamer_pkg.sv
// Shared types and constants for the packed-string character streamer.
// Escape constants are consumed only when ESC_DISPLAY_EN is defined.
package str_stream_pkg;

  localparam int CHAR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_t;

  localparam logic [7:0] ESC_CHAR   = 8'h5C;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] PRINT_MIN  = 8'h20;
  localparam logic [7:0] DEL_CHAR   = 8'h7F;

  function automatic logic is_nonprint(
    input logic [7:0] b
  );
    return (b < PRINT_MIN) || (b == DEL_CHAR);
  endfunction

endpackage

// File: rtl/string_char_streamer_if.sv
// Load and output handshake bundle for string_char_streamer.
// master = string producer / char sink side, slave = the streamer.
interface string_char_streamer_if #(
  parameter int MAX_CHARS = 40
);
  import str_stream_pkg::*;

  logic                        load_valid;
  logic                        load_ready;
  logic [CHAR_W*MAX_CHARS-1:0] load_str;
  logic                        out_valid;
  logic                        out_ready;
  logic [CHAR_W-1:0]           out_char;
  logic                        out_last;

  modport master (
    output load_valid,
    output load_str,
    output out_ready,
    input  load_ready,
    input  out_valid,
    input  out_char,
    input  out_last
  );

  modport slave (
    input  load_valid,
    input  load_str,
    input  out_ready,
    output load_ready,
    output out_valid,
    output out_char,
    output out_last
  );

endinterface

// File: rtl/string_char_streamer_esc_expander.sv
// Expands non-printable bytes into backslash + 3 octal digits.
// Compiled only when ESC_DISPLAY_EN is defined.
`ifdef ESC_DISPLAY_EN
module esc_expander
  import str_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_last,
  output logic       busy
);

  logic       full;
  logic [7:0] byte_q;
  logic       last_q;
  logic [1:0] idx;
  logic       esc;
  logic       fin;

  assign esc       = is_nonprint(byte_q);
  assign fin       = !esc || (idx == 2'd3);
  assign in_ready  = !full;
  assign out_valid = full;
  assign out_last  = last_q && fin;
  assign busy      = full;

  always_comb begin
    out_char = byte_q;
    unique case (1'b1)
      !esc:
        out_char = byte_q;
      esc && (idx == 2'd0):
        out_char = ESC_CHAR;
      esc && (idx == 2'd1):
        out_char = ASCII_ZERO
                 + {6'd0, byte_q[7:6]};
      esc && (idx == 2'd2):
        out_char = ASCII_ZERO
                 + {5'd0, byte_q[5:3]};
      default:
        out_char = ASCII_ZERO
                 + {5'd0, byte_q[2:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      byte_q <= '0;
      last_q <= 1'b0;
      idx    <= 2'd0;
    end else if (in_valid && !full) begin
      full   <= 1'b1;
      byte_q <= in_char;
      last_q <= in_last;
      idx    <= 2'd0;
    end else if (full && out_ready) begin
      if (fin) begin
        full <= 1'b0;
        idx  <= 2'd0;
      end else begin
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/string_char_streamer.sv
// Streams a right-justified packed string one char per beat.
// ESC_DISPLAY_EN: expand non-printables to \ooo octal escapes.
module string_char_streamer
  import str_stream_pkg::*;
#(
  parameter int MAX_CHARS = 40,
  parameter int CNT_W = $clog2(MAX_CHARS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  string_char_streamer_if.slave bus,
  output logic [CNT_W-1:0]     str_len,
  output logic                 busy
);

  localparam int TOP = CHAR_W * MAX_CHARS - 1;
  localparam int NXT = TOP - CHAR_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_CHARS);

  state_t                      state;
  logic [CHAR_W*MAX_CHARS-1:0] sr;
  logic [CNT_W-1:0]            remaining;
  logic [CNT_W-1:0]            rem_dec;
  logic [CHAR_W-1:0]           top_byte;
  logic                        ld_rdy;
  logic                        run;
  logic                        accept;
  logic                        c_valid;
  logic                        c_ready;
  logic [CHAR_W-1:0]           c_char;
  logic                        c_last;

  assign top_byte = sr[TOP -: CHAR_W];
  assign rem_dec  = (remaining == '0) ? '0
                  : remaining - CNT_W'(1);
  assign accept   = bus.load_valid && bus.load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      remaining <= '0;
      str_len   <= '0;
      ld_rdy    <= 1'b1;
      run       <= 1'b0;
      c_valid   <= 1'b0;
      c_char    <= '0;
      c_last    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr        <= bus.load_str;
            remaining <= FULL;
            ld_rdy    <= 1'b0;
            run       <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (remaining == '0) begin
            ld_rdy <= 1'b1;
            run    <= 1'b0;
            state  <= IDLE;
          end else if (top_byte == '0) begin
            sr        <= sr << CHAR_W;
            remaining <= rem_dec;
          end else begin
            str_len <= remaining;
            c_valid <= 1'b1;
            c_char  <= top_byte;
            c_last  <= (remaining == CNT_W'(1));
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (c_ready) begin
            sr        <= sr << CHAR_W;
            remaining <= rem_dec;
            if (remaining <= CNT_W'(1)) begin
              c_valid <= 1'b0;
              c_char  <= '0;
              c_last  <= 1'b0;
              ld_rdy  <= 1'b1;
              run     <= 1'b0;
              state   <= IDLE;
            end else begin
              c_char <= sr[NXT -: CHAR_W];
              c_last <= (remaining == CNT_W'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ESC_DISPLAY_EN
  logic x_busy;

  esc_expander u_esc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (c_valid),
    .in_ready  (c_ready),
    .in_char   (c_char),
    .in_last   (c_last),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_char  (bus.out_char),
    .out_last  (bus.out_last),
    .busy      (x_busy)
  );

  // Hold off the next load until escaped beats drain.
  assign bus.load_ready = ld_rdy && !x_busy;
  assign busy           = run || x_busy;
`else
  assign bus.out_valid  = c_valid;
  assign bus.out_char   = c_char;
  assign bus.out_last   = c_last;
  assign c_ready        = bus.out_ready;
  assign bus.load_ready = ld_rdy;
  assign busy           = run;
`endif

endmodule
